ingress_tlp_router: RTL

//  Packet-level scheduler after the ingress AXIS converter: decodes the TLP header on each SOP beat.

---
 rtl/ingress_tlp_router.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ingress_tlp_router.sv
// ingress_tlp_router
//   Packet-level scheduler that sits after the ingress AXIS converter. The header
//   on each SOP beat is decoded. MRd/MWr packets (type 5'b00000) are steered to the
//   request port, and Cpl/CplD packets (type 5'b01010) to the completion port. All
//   other TLPs are sunk. The chosen route is held until EOP.
//
//   A packet may only start toward one port once the other port's slice is empty or
//   draining. This stops two packets from being emitted concurrently.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   cnt_clr               synchronous clear of the debug counters
//   s_t* / s_sop / s_eop  input stream (DW0 in s_tdata[31:0], type in [28:24])
//   req_t* / req_sop/eop  request output port (one register slice)
//   cpl_t* / cpl_sop/eop  completion output port (one register slice)
//   req/cpl/drop_pkt_cnt  packets finished per class, counted on the EOP beat
//   err_cnt               framing errors (stray non-SOP beat, or SOP inside a packet)
module ingress_tlp_router #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cnt_clr,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic [KEEP_W-1:0] s_tkeep,
  input  logic              s_sop,
  input  logic              s_eop,
  output logic              req_tvalid,
  input  logic              req_tready,
  output logic [DATA_W-1:0] req_tdata,
  output logic [KEEP_W-1:0] req_tkeep,
  output logic              req_sop,
  output logic              req_eop,
  output logic              cpl_tvalid,
  input  logic              cpl_tready,
  output logic [DATA_W-1:0] cpl_tdata,
  output logic [KEEP_W-1:0] cpl_tkeep,
  output logic              cpl_sop,
  output logic              cpl_eop,
  output logic [CNT_W-1:0]  req_pkt_cnt,
  output logic [CNT_W-1:0]  cpl_pkt_cnt,
  output logic [CNT_W-1:0]  drop_pkt_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef enum logic [1:0] {IDLE, FWD_REQ, FWD_CPL, DROP} state_t;
  // Destination of the beat currently presented on the input.
  // CLS_STRAY marks a non-SOP beat that arrives while no packet is open.
  typedef enum logic [1:0] {CLS_REQ, CLS_CPL, CLS_DROP, CLS_STRAY} cls_t;

  state_t state_reg;
  cls_t   dec_cls;
  cls_t   beat_cls;
  logic   beat_ready;
  logic   accept;

  // Index 0 is the request slice, index 1 is the completion slice.
  logic [1:0]        slot_vld_reg;
  logic [DATA_W-1:0] slot_data_reg [2];
  logic [KEEP_W-1:0] slot_keep_reg [2];
  logic [1:0]        slot_sop_reg;
  logic [1:0]        slot_eop_reg;
  logic [1:0]        port_tready;
  logic [1:0]        slot_free;
  logic [1:0]        slot_load;

  // Index order: req, cpl, drop, err.
  logic [CNT_W-1:0]  cnt_reg [4];
  logic [3:0]        cnt_inc;

  assign port_tready = {cpl_tready, req_tready};
  assign slot_free   = ~slot_vld_reg | port_tready;

  always_comb begin
    dec_cls = CLS_DROP;
    if (s_tdata[28:24] == 5'b00000)
      dec_cls = CLS_REQ;
    else if (s_tdata[28:24] == 5'b01010)
      dec_cls = CLS_CPL;

    beat_cls = CLS_STRAY;
    if (s_sop) begin
      beat_cls = dec_cls;
    end else begin
      case (state_reg)
        FWD_REQ: beat_cls = CLS_REQ;
        FWD_CPL: beat_cls = CLS_CPL;
        DROP:    beat_cls = CLS_DROP;
        default: beat_cls = CLS_STRAY;
      endcase
    end

    // A forwarded beat needs its own slice to be free. It also needs the other
    // slice to be free, so that a new packet cannot overtake one still held in
    // the other port. Beats that are sunk are always accepted.
    beat_ready = 1'b1;
    if (beat_cls == CLS_REQ || beat_cls == CLS_CPL)
      beat_ready = &slot_free;
  end

  assign s_tready = rst_n & beat_ready;
  assign accept   = s_tvalid & s_tready;

  assign slot_load[0] = accept & (beat_cls == CLS_REQ);
  assign slot_load[1] = accept & (beat_cls == CLS_CPL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else if (accept) begin
      if (s_eop) begin
        state_reg <= IDLE;
      end else if (s_sop) begin
        case (dec_cls)
          CLS_REQ: state_reg <= FWD_REQ;
          CLS_CPL: state_reg <= FWD_CPL;
          default: state_reg <= DROP;
        endcase
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          slot_vld_reg[gi]  <= 1'b0;
          slot_data_reg[gi] <= '0;
          slot_keep_reg[gi] <= '0;
          slot_sop_reg[gi]  <= 1'b0;
          slot_eop_reg[gi]  <= 1'b0;
        end else if (slot_load[gi]) begin
          slot_vld_reg[gi]  <= 1'b1;
          slot_data_reg[gi] <= s_tdata;
          slot_keep_reg[gi] <= s_tkeep;
          slot_sop_reg[gi]  <= s_sop;
          slot_eop_reg[gi]  <= s_eop;
        end else if (port_tready[gi]) begin
          slot_vld_reg[gi]  <= 1'b0;
        end
      end
    end
  endgenerate

  assign cnt_inc[0] = accept & s_eop & (beat_cls == CLS_REQ);
  assign cnt_inc[1] = accept & s_eop & (beat_cls == CLS_CPL);
  assign cnt_inc[2] = accept & s_eop & (beat_cls == CLS_DROP);
  assign cnt_inc[3] = accept & ((beat_cls == CLS_STRAY) | (s_sop & (state_reg != IDLE)));

  generate
    for (gi = 0; gi < 4; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr)
          cnt_reg[gi] <= '0;
        else if (cnt_inc[gi])
          cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
      end
    end
  endgenerate

  assign req_tvalid   = slot_vld_reg[0];
  assign req_tdata    = slot_data_reg[0];
  assign req_tkeep    = slot_keep_reg[0];
  assign req_sop      = slot_sop_reg[0];
  assign req_eop      = slot_eop_reg[0];
  assign cpl_tvalid   = slot_vld_reg[1];
  assign cpl_tdata    = slot_data_reg[1];
  assign cpl_tkeep    = slot_keep_reg[1];
  assign cpl_sop      = slot_sop_reg[1];
  assign cpl_eop      = slot_eop_reg[1];
  assign req_pkt_cnt  = cnt_reg[0];
  assign cpl_pkt_cnt  = cnt_reg[1];
  assign drop_pkt_cnt = cnt_reg[2];
  assign err_cnt      = cnt_reg[3];

endmodule
